// File: rtl/neighbor_id_unpacker.sv
// neighbor_id_unpacker: buffers packed neighbor words and emits one neighbor ID per handshake; 2-cycle write-to-valid latency.
// full is a registered almost-full with SKID words of headroom; NEIGHBOR_UNPACK_STATS_EN adds saturating word/id/drop counters.

module nbr_word_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign rd_dat = mem[rd_ptr];
endmodule

module neighbor_id_unpacker #(
  parameter int ID_W         = 10,
  parameter int NBR_PER_WORD = 4,
  parameter int ITER_W       = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int SKID         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [ID_W-1:0]                in_node_id,
  input  logic [$clog2(NBR_PER_WORD+1)-1:0] in_nbr_cnt,
  input  logic [NBR_PER_WORD*ID_W-1:0]   in_nbr_ids,
  input  logic                           in_last_word,
  input  logic [ITER_W-1:0]              in_replay_iter,
  output logic                           full,
  output logic                           overflow,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_node_id,
  output logic [ID_W-1:0]                out_nbr_id,
  output logic [ITER_W-1:0]              out_replay_iter,
  output logic                           out_last
`ifdef NEIGHBOR_UNPACK_STATS_EN
  ,
  output logic [15:0]                    stat_words,
  output logic [15:0]                    stat_ids,
  output logic [7:0]                     stat_drops
`endif
);
  localparam int CNT_W = $clog2(NBR_PER_WORD+1);
  localparam int OCC_W = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [ID_W-1:0]              node_id;
    logic [CNT_W-1:0]             cnt;
    logic [NBR_PER_WORD*ID_W-1:0] ids;
    logic                         last_word;
    logic [ITER_W-1:0]            iter;
  } word_t;

  typedef enum logic {IDLE, UNPACK} state_t;

  state_t           state_q, state_d;
  word_t            word_q, word_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  word_t            in_word;
  word_t            head;
  logic [OCC_W-1:0] occ;
  logic             fifo_empty;
  logic             pop;
  logic             wr_en;
  logic             at_end;
  logic             full_d;
  int               occ_next;

  // Count is clamped on entry so the unpacker only ever sees 0..NBR_PER_WORD.
  always_comb begin
    in_word           = '0;
    in_word.node_id   = in_node_id;
    in_word.cnt       = (in_nbr_cnt > CNT_W'(NBR_PER_WORD)) ? CNT_W'(NBR_PER_WORD) : in_nbr_cnt;
    in_word.ids       = in_nbr_ids;
    in_word.last_word = in_last_word;
    in_word.iter      = in_replay_iter;
  end

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign wr_en = in_valid && ((occ < OCC_W'(FIFO_DEPTH)) || pop);

  nbr_word_fifo #(
    .DW    ($bits(word_t)),
    .DEPTH (FIFO_DEPTH),
    .CW    (OCC_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_dat (in_word),
    .rd_en  (pop),
    .rd_dat (head),
    .count  (occ)
  );

  assign fifo_empty = (occ == '0);
  assign at_end     = (idx_q == word_q.cnt - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // Zero-count words are consumed here and never reach the output.
          if (head.cnt != '0) begin
            word_d  = head;
            idx_d   = '0;
            state_d = UNPACK;
          end
        end
      end
      UNPACK: begin
        if (out_ready) begin
          if (!at_end) begin
            idx_d = idx_q + CNT_W'(1);
          end else if (!fifo_empty) begin
            pop = 1'b1;
            if (head.cnt != '0) begin
              word_d = head;
              idx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_next = int'(occ) + int'(wr_en) - int'(pop);
    full_d   = (occ_next >= (FIFO_DEPTH - SKID));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      idx_q    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      full     <= full_d;
      overflow <= overflow | (in_valid & ~wr_en);
    end
  end

  assign out_valid       = (state_q == UNPACK);
  assign out_node_id     = word_q.node_id;
  assign out_nbr_id      = word_q.ids[idx_q*ID_W +: ID_W];
  assign out_replay_iter = word_q.iter;
  assign out_last        = word_q.last_word & at_end & (state_q == UNPACK);

`ifdef NEIGHBOR_UNPACK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_words <= '0;
      stat_ids   <= '0;
      stat_drops <= '0;
    end else begin
      if (wr_en && (stat_words != '1)) stat_words <= stat_words + 16'd1;
      if (out_valid && out_ready && (stat_ids != '1)) stat_ids <= stat_ids + 16'd1;
      if (in_valid && !wr_en && (stat_drops != '1)) stat_drops <= stat_drops + 8'd1;
    end
  end
`endif
endmodule
